pe_ws_dbuf: RTL and testbench

Next-generation weight-stationary processing element for the systolic array.
- Data and accumulator widths are parametrised.
- The weight is double-buffered: the next tile's weight preloads into a shadow register while the MAC computes.
- Weight and control forward vertically; activations forward horizontally.
- The accumulator saturates and drains through a valid/ready result port.
- Instantiated as an R x C grid by the array top.

---
 rtl/pe_ws_dbuf_pkg.sv | 55 +++++
 rtl/pe_ws_dbuf_if.sv | 23 ++
 rtl/pe_ws_dbuf_mac_sat.sv | 72 +++++++
 rtl/pe_ws_dbuf.sv | 164 ++++++++++++++++
 tb/tb_pe_ws_dbuf.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pe_ws_dbuf_pkg.sv
// Shared definitions for the weight-stationary PE: default widths,
// accumulator limits, the result record and the saturating adder.
package pe_pkg;

    localparam int A_W_DEF   = 8;
    localparam int W_W_DEF   = 8;
    localparam int ACC_W_DEF = 32;

    // Internal arithmetic width; any ACC_W up to 63 bits fits without loss.
    localparam int ACC_MAX_W = 64;

    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Result record: value (sign-extended to the internal width) plus overflow flag.
    typedef struct packed {
        logic [ACC_MAX_W-1:0] data;
        logic                 ovf;
    } pe_res_t;

    // Largest representable value of an acc_w-bit signed accumulator.
    function automatic logic signed [ACC_MAX_W-1:0] acc_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    // Smallest representable value of an acc_w-bit signed accumulator.
    function automatic logic signed [ACC_MAX_W-1:0] acc_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

    // Adds two in-range operands; flags overflow of the acc_w-bit result and
    // either clamps to the nearest limit or wraps in two's complement.
    function automatic pe_res_t sat_add(input logic signed [ACC_MAX_W-1:0] a,
                                        input logic signed [ACC_MAX_W-1:0] b,
                                        input int                          acc_w,
                                        input logic                        saturate);
        logic signed [ACC_MAX_W-1:0] sum;
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        logic signed [ACC_MAX_W-1:0] wrapped;
        pe_res_t                     r;
        sum     = a + b;
        hi      = acc_max(acc_w);
        lo      = acc_min(acc_w);
        wrapped = (sum <<< (ACC_MAX_W - acc_w)) >>> (ACC_MAX_W - acc_w);
        r.ovf   = (sum > hi) || (sum < lo);
        if (r.ovf && saturate) begin
            r.data = (sum > hi) ? hi : lo;
        end else begin
            r.data = wrapped;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_ws_dbuf_if.sv
// Result port of the PE: snapshot value and overflow with a valid/ready handshake.
interface pe_res_if #(
    parameter int ACC_W = 32
);
    logic [ACC_W-1:0] res_data;
    logic             res_ovf;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output res_data,
        output res_ovf,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_ovf,
        input  res_valid,
        output res_ready
    );
endinterface

// File: rtl/pe_ws_dbuf_mac_sat.sv
// Multiply-accumulate core: signed product, saturating/wrapping accumulate,
// sticky overflow and a restart input that reseeds the accumulator.
module pe_mac_sat
    import pe_pkg::*;
#(
    parameter int A_W         = A_W_DEF,
    parameter int W_W         = W_W_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter bit SATURATE    = 1'b1,
    parameter bit ZERO_BYPASS = 1'b1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [W_W-1:0]   w,
    input  logic                    en,
    input  logic                    restart,
    output logic signed [ACC_W-1:0] acc,
    output logic                    ovf
);

    localparam int P_W = A_W + W_W;

    logic signed [P_W-1:0]       prod;
    logic signed [ACC_MAX_W-1:0] prod_ext;
    logic signed [ACC_MAX_W-1:0] acc_ext;
    logic                        zero_op;
    pe_res_t                     sum_r;
    pe_res_t                     seed_r;

    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     acc_d;
    logic                        ovf_q;
    logic                        ovf_d;

    assign prod     = a * w;
    assign prod_ext = {{(ACC_MAX_W-P_W){prod[P_W-1]}}, prod};
    assign acc_ext  = {{(ACC_MAX_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign zero_op  = (a == '0) || (w == '0);
    assign sum_r    = sat_add(acc_ext, prod_ext, ACC_W, SATURATE);
    assign seed_r   = sat_add('0, prod_ext, ACC_W, SATURATE);

    // Next accumulator: restart reseeds with this cycle's product (or zero);
    // otherwise accumulate when enabled. A zero operand adds nothing, so
    // skipping the update leaves the numeric result unchanged.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (restart) begin
            acc_d = en ? seed_r.data[ACC_W-1:0] : '0;
            ovf_d = en & seed_r.ovf;
        end else if (en && !(ZERO_BYPASS && zero_op)) begin
            acc_d = sum_r.data[ACC_W-1:0];
            ovf_d = ovf_q | sum_r.ovf;
        end
    end

    // Accumulator and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with a double-buffered weight, systolic forwarding
// and a drainable result slot.
module pe_ws_dbuf
    import pe_pkg::*;
#(
    parameter int A_W         = A_W_DEF,
    parameter int W_W         = W_W_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter bit PIPE        = 1'b1,
    parameter bit SATURATE    = 1'b1,
    parameter bit ZERO_BYPASS = 1'b1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [A_W-1:0]   a_in,
    input  logic                    en,
    output logic signed [A_W-1:0]   a_out,
    output logic                    en_out,
    input  logic signed [W_W-1:0]   b_in,
    input  logic                    load_weight,
    input  logic                    swap,
    output logic signed [W_W-1:0]   b_out,
    output logic                    load_weight_out,
    output logic                    swap_out,
    input  logic                    clr,
    input  logic                    drain,
    pe_res_if.master                res,
    output logic signed [ACC_W-1:0] acc,
    output logic                    drain_err
);

    logic signed [W_W-1:0]   weight_shd_q, weight_shd_d;
    logic signed [W_W-1:0]   weight_act_q, weight_act_d;
    logic signed [W_W-1:0]   b_out_q, b_out_d;
    logic                    load_weight_out_q, load_weight_out_d;
    logic                    swap_out_q, swap_out_d;
    logic [ACC_W-1:0]        res_data_q, res_data_d;
    logic                    res_ovf_q, res_ovf_d;
    logic                    res_valid_q, res_valid_d;
    logic                    drain_err_q, drain_err_d;

    logic                    drain_acc;
    logic                    restart;
    logic signed [ACC_W-1:0] mac_acc;
    logic                    mac_ovf;

    // Horizontal forwarding: registered or pass-through.
    generate
        if (PIPE) begin : g_pipe
            logic signed [A_W-1:0] a_out_q, a_out_d;
            logic                  en_out_q, en_out_d;

            // Next values of the horizontal forwarding stage.
            always_comb begin
                a_out_d  = a_in;
                en_out_d = en;
            end

            // Horizontal forwarding registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_out_q  <= '0;
                    en_out_q <= 1'b0;
                end else begin
                    a_out_q  <= a_out_d;
                    en_out_q <= en_out_d;
                end
            end

            assign a_out  = a_out_q;
            assign en_out = en_out_q;
        end else begin : g_comb
            assign a_out  = a_in;
            assign en_out = en;
        end
    endgenerate

    // Drain is taken when the slot is empty or is being emptied this cycle.
    assign drain_acc = drain && (!res_valid_q || res.res_ready);
    assign restart   = clr || drain_acc;

    // Weight shadow/active update and vertical forwarding. A simultaneous
    // load and swap moves the old shadow value into the active weight.
    always_comb begin
        weight_shd_d      = load_weight ? b_in : weight_shd_q;
        weight_act_d      = swap ? weight_shd_q : weight_act_q;
        b_out_d           = b_in;
        load_weight_out_d = load_weight;
        swap_out_d        = swap;
    end

    // Result slot and drain error. The snapshot is the accumulator before
    // this cycle's product; a refused drain only raises the sticky error.
    always_comb begin
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = res_valid_q;
        drain_err_d = drain_err_q;
        if (drain_acc) begin
            res_data_d  = mac_acc;
            res_ovf_d   = mac_ovf;
            res_valid_d = 1'b1;
        end else if (res_valid_q && res.res_ready) begin
            res_valid_d = 1'b0;
        end
        if (clr) begin
            drain_err_d = 1'b0;
        end else if (drain && !drain_acc) begin
            drain_err_d = 1'b1;
        end
    end

    // Weight, forwarding and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_shd_q      <= '0;
            weight_act_q      <= '0;
            b_out_q           <= '0;
            load_weight_out_q <= 1'b0;
            swap_out_q        <= 1'b0;
            res_data_q        <= '0;
            res_ovf_q         <= 1'b0;
            res_valid_q       <= 1'b0;
            drain_err_q       <= 1'b0;
        end else begin
            weight_shd_q      <= weight_shd_d;
            weight_act_q      <= weight_act_d;
            b_out_q           <= b_out_d;
            load_weight_out_q <= load_weight_out_d;
            swap_out_q        <= swap_out_d;
            res_data_q        <= res_data_d;
            res_ovf_q         <= res_ovf_d;
            res_valid_q       <= res_valid_d;
            drain_err_q       <= drain_err_d;
        end
    end

    pe_mac_sat #(
        .A_W         (A_W),
        .W_W         (W_W),
        .ACC_W       (ACC_W),
        .SATURATE    (SATURATE),
        .ZERO_BYPASS (ZERO_BYPASS)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a_in),
        .w       (weight_act_q),
        .en      (en),
        .restart (restart),
        .acc     (mac_acc),
        .ovf     (mac_ovf)
    );

    assign b_out           = b_out_q;
    assign load_weight_out = load_weight_out_q;
    assign swap_out        = swap_out_q;
    assign res.res_data    = res_data_q;
    assign res.res_ovf     = res_ovf_q;
    assign res.res_valid   = res_valid_q;
    assign acc             = mac_acc;
    assign drain_err       = drain_err_q;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Directed bench for pe_ws_dbuf: a saturating/pipelined instance (u1) and a
// wrapping/pass-through/no-bypass instance (u2) share the same stimulus.
module tb_pe_ws_dbuf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [7:0] a_in = '0;
    logic signed [7:0] b_in = '0;
    logic en = 1'b0, lw = 1'b0, sw = 1'b0, clr = 1'b0, drain = 1'b0, rdy = 1'b0;

    logic signed [7:0]  a_out1, b_out1, a_out2, b_out2;
    logic               en_out1, lwo1, swo1, derr1;
    logic               en_out2, lwo2, swo2, derr2;
    logic signed [15:0] acc1, acc2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pe_res_if #(.ACC_W(16)) r1();
    pe_res_if #(.ACC_W(16)) r2();
    assign r1.res_ready = rdy;
    assign r2.res_ready = rdy;

    pe_ws_dbuf #(.A_W(8), .W_W(8), .ACC_W(16), .PIPE(1'b1), .SATURATE(1'b1), .ZERO_BYPASS(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .en(en), .a_out(a_out1), .en_out(en_out1),
        .b_in(b_in), .load_weight(lw), .swap(sw), .b_out(b_out1), .load_weight_out(lwo1),
        .swap_out(swo1), .clr(clr), .drain(drain), .res(r1.master), .acc(acc1), .drain_err(derr1));

    pe_ws_dbuf #(.A_W(8), .W_W(8), .ACC_W(16), .PIPE(1'b0), .SATURATE(1'b0), .ZERO_BYPASS(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .en(en), .a_out(a_out2), .en_out(en_out2),
        .b_in(b_in), .load_weight(lw), .swap(sw), .b_out(b_out2), .load_weight_out(lwo2),
        .swap_out(swo2), .clr(clr), .drain(drain), .res(r2.master), .acc(acc2), .drain_err(derr2));

    typedef struct {
        logic              lw, sw, en, clr, drain, rdy;
        logic signed [7:0] b, a;
        int                e_acc;
        logic              e_rv;
        int                e_rd;
        logic              e_derr;
        int                e_bout;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic l, input int b, input logic s, input logic e,
                         input int a, input logic c, input logic d, input logic r);
        lw = l; b_in = 8'(b); sw = s; en = e; a_in = 8'(a); clr = c; drain = d; rdy = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lw b sw en a clr drain rdy | acc rv rd derr bout
    task automatic add(input logic l, input int b, input logic s, input logic e, input int a,
                       input logic c, input logic d, input logic r,
                       input int ea, input logic erv, input int erd, input logic ederr, input int eb);
        vec_t v;
        v.lw = l; v.b = 8'(b); v.sw = s; v.en = e; v.a = 8'(a); v.clr = c; v.drain = d; v.rdy = r;
        v.e_acc = ea; v.e_rv = erv; v.e_rd = erd; v.e_derr = ederr; v.e_bout = eb;
        vq.push_back(v);
    endtask

    initial begin
        // preload and swap
        add(1,  3, 0, 0,  0, 0, 0, 0,   0, 0,   0, 0,  3);
        add(0,  0, 1, 0,  0, 0, 0, 0,   0, 0,   0, 0,  0);
        add(0,  0, 0, 1,  2, 0, 0, 0,   6, 0,   0, 0,  0);
        add(0,  0, 0, 1,  4, 0, 0, 0,  18, 0,   0, 0,  0);
        add(0,  0, 0, 1, -1, 0, 0, 0,  15, 0,   0, 0,  0);
        // overlapped load; swap-cycle product uses the old weight
        add(0,  0, 0, 0,  0, 1, 0, 0,   0, 0,   0, 0,  0);
        add(1, -2, 0, 1,  5, 0, 0, 0,  15, 0,   0, 0, -2);
        add(0,  0, 1, 1,  5, 0, 0, 0,  30, 0,   0, 0,  0);
        add(0,  0, 0, 1,  5, 0, 0, 0,  20, 0,   0, 0,  0);
        // build acc=100 with weight 10, then stage weight 7
        add(1, 10, 0, 0,  0, 1, 0, 0,   0, 0,   0, 0, 10);
        add(0,  0, 1, 0,  0, 0, 0, 0,   0, 0,   0, 0,  0);
        add(1,  7, 0, 1, 10, 0, 0, 0, 100, 0,   0, 0,  7);
        add(0,  0, 1, 0,  0, 0, 0, 0, 100, 0,   0, 0,  0);
        // drain with en, stalled drain, release
        add(0,  0, 0, 1,  1, 0, 1, 0,   7, 1, 100, 0,  0);
        add(0,  0, 0, 1,  1, 0, 1, 0,  14, 1, 100, 1,  0);
        add(0,  0, 0, 0,  0, 0, 0, 1,  14, 0, 100, 1,  0);
        // clr with en reseeds and clears the error
        add(0,  0, 0, 1,  3, 1, 0, 0,  21, 0, 100, 0,  0);
        // back-to-back drain
        add(0,  0, 0, 0,  0, 0, 1, 0,   0, 1,  21, 0,  0);
        add(0,  0, 0, 1,  2, 0, 0, 0,  14, 1,  21, 0,  0);
        add(0,  0, 0, 0,  0, 0, 1, 1,   0, 1,  14, 0,  0);
        add(0,  0, 0, 0,  0, 0, 0, 1,   0, 0,  14, 0,  0);
        // zero operand holds the accumulator
        add(0,  0, 0, 1,  0, 0, 0, 0,   0, 0,  14, 0,  0);
        // drain together with clr and en
        add(0,  0, 0, 1,  3, 1, 1, 0,  21, 1,   0, 0,  0);

        // reset state
        #2;
        chk("rst_acc", acc1, 0);
        chk("rst_res_valid", r1.res_valid, 0);
        chk("rst_res_data", $signed(r1.res_data), 0);
        chk("rst_drain_err", derr1, 0);
        chk("rst_b_out", b_out1, 0);
        chk("rst_a_out", a_out1, 0);
        chk("rst_lwo", lwo1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // forwarding: registered vs pass-through
        @(negedge clk);
        drive(0, 0, 0, 1, 42, 0, 0, 0);
        #1;
        chk("comb_a_out", a_out2, 42);
        chk("comb_en_out", en_out2, 1);
        chk("pipe_a_out_pre", a_out1, 0);
        tick();
        chk("pipe_a_out", a_out1, 42);
        chk("pipe_en_out", en_out1, 1);
        chk("acc_zero_weight", acc1, 0);

        // table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].lw, vq[i].b, vq[i].sw, vq[i].en, vq[i].a, vq[i].clr, vq[i].drain, vq[i].rdy);
            tick();
            $display("vec %0d: acc=%0d rv=%0d rd=%0d derr=%0d", i, acc1, r1.res_valid,
                     $signed(r1.res_data), derr1);
            chk($sformatf("v%0d_acc", i), acc1, vq[i].e_acc);
            chk($sformatf("v%0d_acc_u2", i), acc2, vq[i].e_acc);
            chk($sformatf("v%0d_res_valid", i), r1.res_valid, vq[i].e_rv);
            chk($sformatf("v%0d_res_data", i), $signed(r1.res_data), vq[i].e_rd);
            chk($sformatf("v%0d_drain_err", i), derr1, vq[i].e_derr);
            chk($sformatf("v%0d_b_out", i), b_out1, vq[i].e_bout);
            chk($sformatf("v%0d_lwo", i), lwo1, vq[i].lw);
            chk($sformatf("v%0d_swo", i), swo1, vq[i].sw);
        end

        // saturation vs wrap, weight 127 x a 127
        @(negedge clk); drive(1, 127, 0, 0, 0, 1, 0, 1); tick();
        chk("sat_clr", acc1, 0);
        @(negedge clk); drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        @(negedge clk); drive(0, 0, 0, 1, 127, 0, 0, 0); tick();
        $display("sat1: acc1=%0d acc2=%0d", acc1, acc2);
        chk("sat1_acc", acc1, 16129);
        @(negedge clk); tick();
        $display("sat2: acc1=%0d acc2=%0d", acc1, acc2);
        chk("sat2_acc", acc1, 32258);
        chk("sat2_acc_u2", acc2, 32258);
        @(negedge clk); tick();
        $display("sat3: acc1=%0d acc2=%0d", acc1, acc2);
        chk("sat3_clamp", acc1, 32767);
        chk("sat3_wrap", acc2, -17149);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        $display("sat drain: rd1=%0d ovf1=%0d rd2=%0d ovf2=%0d", $signed(r1.res_data), r1.res_ovf,
                 $signed(r2.res_data), r2.res_ovf);
        chk("sat_res_data", $signed(r1.res_data), 32767);
        chk("sat_res_ovf", r1.res_ovf, 1);
        chk("wrap_res_data", $signed(r2.res_data), -17149);
        chk("wrap_res_ovf", r2.res_ovf, 1);
        chk("sat_restart_acc", acc1, 0);

        // asynchronous reset mid-run
        @(negedge clk); drive(1, 5, 0, 0, 0, 1, 0, 1); tick();
        @(negedge clk); drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        @(negedge clk); drive(0, 0, 0, 1, 11, 0, 0, 0); tick();
        chk("pre_rst_acc", acc1, 55);
        @(negedge clk); drive(0, 0, 0, 1, 11, 0, 1, 0); tick();
        chk("pre_rst_res_valid", r1.res_valid, 1);
        chk("pre_rst_res_data", $signed(r1.res_data), 55);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        $display("async reset: acc=%0d rv=%0d rd=%0d", acc1, r1.res_valid, $signed(r1.res_data));
        chk("async_acc", acc1, 0);
        chk("async_acc_u2", acc2, 0);
        chk("async_res_valid", r1.res_valid, 0);
        chk("async_res_data", $signed(r1.res_data), 0);
        #1 rst_n = 1'b1;
        @(negedge clk); drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        @(negedge clk); drive(0, 0, 0, 1, 9, 0, 0, 0); tick();
        chk("post_rst_zero_weight", acc1, 0);
        chk("post_rst_zero_weight_u2", acc2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
